pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage. Holds the program counter, drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register.
- Produces the next PC by word-increment (PC+1, word-addressed) or by branch/jump redirect.
- Handles stall and redirect-flush, and runs a BOOT/RUN/HALT state machine.
- Sits between instruction memory and the decode stage; branch redirect comes from EX, jump redirect from ID.

Parameters:
- ADDR_W, 32, PC and address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction inserted into IF/ID on a bubble.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard-unit stall; hold PC and IF/ID.
- branch_taken_i  in  1  EX-stage branch resolved taken.
- branch_target_i  in  ADDR_W  branch target word address.
- jump_i  in  1  ID-stage jump.
- jump_target_i  in  ADDR_W  jump target word address.
- halt_i  in  1  stop fetching (sticky until reset).
- imem_addr_o  out  ADDR_W  instruction memory address; equals pc_o.
- imem_rdata_i  in  DATA_W  instruction word; combinational read of imem_addr_o.
- pc_o  out  ADDR_W  current PC.
- if_id_instr_o  out  DATA_W  registered instruction.
- if_id_pc_plus1_o  out  ADDR_W  registered PC+1 of that instruction.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  high in HALT state.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values, applied immediately while rst_n=0:
  - pc_o = RESET_PC
  - if_id_instr_o = NOP_INSTR
  - if_id_pc_plus1_o = 0
  - if_id_valid_o = 0
  - halted_o = 0
  - state = BOOT
- States:
  - BOOT: the first edge after reset release goes BOOT->RUN. PC is not advanced and IF/ID stays a bubble. The first valid instruction appears in IF/ID on the second edge after release.
  - RUN: normal fetch.
  - HALT: PC frozen, IF/ID forced to bubble, halted_o=1. Only reset leaves HALT.
- Transitions: BOOT->RUN unconditionally. RUN->HALT when halt_i=1 at an edge. HALT->HALT otherwise.
- Next-PC priority in RUN, evaluated per edge, highest first:
  1. branch_taken_i: PC<=branch_target_i; IF/ID<=bubble (valid=0, instr=NOP_INSTR, pc_plus1=0).
  2. jump_i: PC<=jump_target_i; IF/ID<=bubble.
  3. stall_i: PC and IF/ID hold their values.
  4. otherwise: PC<=PC+1; IF/ID<=(imem_rdata_i, PC+1, valid=1).
- Simultaneous events:
  - Redirect beats stall, because the older instruction's redirect must not be lost.
  - Branch beats jump.
  - halt_i beats everything: on the halt edge PC holds and IF/ID becomes a bubble.
- Arithmetic: PC+1 is modulo 2^ADDR_W, so all-ones wraps to 0 with no flag. Targets are taken verbatim with no alignment check.
- Latency: imem_rdata_i reaches IF/ID one edge after its address is presented.
- Inputs ignored outside RUN: stall_i, branch_taken_i and jump_i are don't-care in BOOT and HALT.
- Mid-operation reset: asserting rst_n low in any state returns all registers to reset values asynchronously. A pending stall or redirect is discarded.
- imem_addr_o is a continuous copy of pc_o; there is no extra register.

Decomposition:
- Shared package (pipeline_pkg):
  - ADDR_W and DATA_W constants
  - NOP_INSTR constant
  - fetch_state_t enum {BOOT, RUN, HALT}
  - if_id_t struct {instr, pc_plus1, valid}
- Sub-module: next_pc_sel, a combinational priority mux. It takes pc, the targets, the control bits and the state, and produces next_pc, load_if_id and bubble.
- The word incrementer reuses the existing PC+1 adder inside next_pc_sel.
- The registers and FSM live in pc_fetch_unit.

Test Plan:
- Reset then release, imem returns 32'hAAAA0001 at addr 0.
  - BOOT edge: valid=0, pc=0.
  - Next edge: pc=1, if_id_instr=32'hAAAA0001, pc_plus1=1, valid=1.
- Sequential run with imem data = address + 32'h100, for 4 edges after BOOT.
  - pc goes 1,2,3,4.
  - if_id_instr goes 0x100,0x101,0x102,0x103, each with valid=1.
- At pc=5, assert stall_i=1 for 2 edges, then assert branch_taken_i=1 with target=32'h40 while stall_i is still 1.
  - During the stall: pc and IF/ID hold.
  - On the branch edge: pc=0x40, valid=0, instr=NOP.
- branch_taken_i=1 (target 0x80) and jump_i=1 (target 0x20) on the same edge.
  - pc=0x80 and IF/ID bubble.
  - Next edge: pc=0x81, valid=1.
- Jump to target 32'hFFFF_FFFF, then one free edge.
  - pc wraps to 0.
  - if_id_pc_plus1_o=0, valid=1.
- halt_i pulse at pc=0x10.
  - halted_o=1, pc stays 0x10 for 5 edges despite jump_i=1, valid=0.
- Assert rst_n=0 mid-cycle while in HALT.
  - Without waiting for an edge: pc=RESET_PC, halted_o=0, valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants: widths, bubble instruction, FSM states, IF/ID payload.
package pipeline_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(0);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus1;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall/halt controls, instruction-memory port and IF/ID outputs.
interface pc_fetch_unit_if;
  import pipeline_pkg::*;

  logic              stall_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_target_i;
  logic              halt_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [DATA_W-1:0] imem_rdata_i;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] if_id_instr_o;
  logic [ADDR_W-1:0] if_id_pc_plus1_o;
  logic              if_id_valid_o;
  logic              halted_o;

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           halt_i, imem_rdata_i,
    output imem_addr_o, pc_o, if_id_instr_o, if_id_pc_plus1_o, if_id_valid_o,
           halted_o
  );

  modport master (
    output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           halt_i, imem_rdata_i,
    input  imem_addr_o, pc_o, if_id_instr_o, if_id_pc_plus1_o, if_id_valid_o,
           halted_o
  );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: halt > branch > jump > stall > PC+1, gated by fetch state.
module next_pc_sel
  import pipeline_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  fetch_state_t      state_i,
  output logic [ADDR_W-1:0] next_pc_o_c,
  output logic [ADDR_W-1:0] pc_plus1_o_c,
  output logic              load_if_id_o_c,
  output logic              bubble_o_c
);

  assign pc_plus1_o_c = pc_i + ADDR_W'(1);

  // BOOT and HALT freeze the PC and keep IF/ID a bubble; control inputs only matter in RUN.
  always_comb begin
    next_pc_o_c    = pc_i;
    load_if_id_o_c = 1'b1;
    bubble_o_c     = 1'b1;
    if (state_i == RUN) begin
      if (halt_i) begin
        next_pc_o_c = pc_i;
      end else if (branch_taken_i) begin
        next_pc_o_c = branch_target_i;
      end else if (jump_i) begin
        next_pc_o_c = jump_target_i;
      end else if (stall_i) begin
        load_if_id_o_c = 1'b0;
        bubble_o_c     = 1'b0;
      end else begin
        next_pc_o_c = pc_plus1_o_c;
        bubble_o_c  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT sequencing.
module pc_fetch_unit #(
  parameter logic [pipeline_pkg::ADDR_W-1:0] RESET_PC  = pipeline_pkg::ADDR_W'(0),
  parameter logic [pipeline_pkg::DATA_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.slave  bus
);
  import pipeline_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  if_id_t            if_id_q, if_id_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              load_if_id;
  logic              bubble;

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .branch_taken_i  (bus.branch_taken_i),
    .branch_target_i (bus.branch_target_i),
    .jump_i          (bus.jump_i),
    .jump_target_i   (bus.jump_target_i),
    .stall_i         (bus.stall_i),
    .halt_i          (bus.halt_i),
    .state_i         (state_q),
    .next_pc_o_c     (next_pc),
    .pc_plus1_o_c    (pc_plus1),
    .load_if_id_o_c  (load_if_id),
    .bubble_o_c      (bubble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc_plus1 <= ADDR_W'(0);
      if_id_q.valid    <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      halted_q <= halted_d;
    end
  end

  // Next state plus PC / IF/ID update; a bubble clears the whole payload.
  always_comb begin
    state_d  = state_q;
    pc_d     = next_pc;
    if_id_d  = if_id_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = bus.halt_i ? HALT : RUN;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALT);
    if (load_if_id) begin
      if (bubble) begin
        if_id_d.instr    = NOP_INSTR;
        if_id_d.pc_plus1 = ADDR_W'(0);
        if_id_d.valid    = 1'b0;
      end else begin
        if_id_d.instr    = bus.imem_rdata_i;
        if_id_d.pc_plus1 = pc_plus1;
        if_id_d.valid    = 1'b1;
      end
    end
  end

  assign bus.imem_addr_o      = pc_q;
  assign bus.pc_o             = pc_q;
  assign bus.if_id_instr_o    = if_id_q.instr;
  assign bus.if_id_pc_plus1_o = if_id_q.pc_plus1;
  assign bus.if_id_valid_o    = if_id_q.valid;
  assign bus.halted_o         = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized redirects/stalls against a behavioural model.
module tb_pc_fetch_unit;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  function automatic logic [31:0] imem_f(input logic [31:0] a, input int md);
    if (md == 0)      return (a == 32'h0) ? 32'hAAAA_0001 : a + 32'h100;
    else if (md == 1) return a + 32'h100;
    else              return (a * 32'h9E37_79B1) ^ 32'h1234_ABCD;
  endfunction

  always_comb bus.imem_rdata_i = imem_f(bus.imem_addr_o, mode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch-stage rules applied once per rising edge.
  int          m_st;
  logic [31:0] m_pc, m_instr, m_pp1;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_BOOT; m_pc <= 32'h0;
      m_instr <= 32'h0; m_pp1 <= 32'h0; m_valid <= 1'b0;
    end else if (m_st == M_BOOT) begin
      m_st <= M_RUN;
    end else if (m_st == M_RUN) begin
      if (bus.halt_i || bus.branch_taken_i || bus.jump_i) begin
        m_instr <= 32'h0; m_pp1 <= 32'h0; m_valid <= 1'b0;
        if (bus.halt_i)              m_st <= M_HALT;
        else if (bus.branch_taken_i) m_pc <= bus.branch_target_i;
        else                         m_pc <= bus.jump_target_i;
      end else if (!bus.stall_i) begin
        m_instr <= imem_f(m_pc, mode);
        m_pp1   <= m_pc + 32'h1;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 32'h1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pc",        bus.pc_o,             m_pc);
      chk("imem_addr", bus.imem_addr_o,      m_pc);
      chk("instr",     bus.if_id_instr_o,    m_instr);
      chk("pc_plus1",  bus.if_id_pc_plus1_o, m_pp1);
      chk("valid",     32'(bus.if_id_valid_o), 32'(m_valid));
      chk("halted",    32'(bus.halted_o),      32'(m_st == M_HALT));
    end
  end

  task automatic clear_inputs();
    bus.stall_i = 1'b0; bus.branch_taken_i = 1'b0; bus.jump_i = 1'b0; bus.halt_i = 1'b0;
    bus.branch_target_i = 32'h0; bus.jump_target_i = 32'h0;
  endtask

  task automatic do_reset(input int md);
    @(negedge clk);
    rst_n = 1'b0;
    mode  = md;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bus.branch_taken_i  = ($urandom_range(7) == 0);
      bus.jump_i          = ($urandom_range(7) == 0);
      bus.stall_i         = ($urandom_range(3) == 0);
      bus.branch_target_i = $urandom;
      bus.jump_target_i   = (i % 37 == 5) ? 32'hFFFF_FFFF : $urandom;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    mode  = 0;
    #12;
    chk("rst_pc",     bus.pc_o, 32'h0);
    chk("rst_valid",  32'(bus.if_id_valid_o), 32'h0);
    chk("rst_halted", 32'(bus.halted_o), 32'h0);
    chk("rst_instr",  bus.if_id_instr_o, 32'h0);
    chk("rst_pp1",    bus.if_id_pc_plus1_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("boot_pc",    bus.pc_o, 32'h0);
    @(negedge clk);
    chk("first_pc",    bus.pc_o, 32'h1);
    chk("first_instr", bus.if_id_instr_o, 32'hAAAA_0001);
    chk("first_pp1",   bus.if_id_pc_plus1_o, 32'h1);
    chk("first_valid", 32'(bus.if_id_valid_o), 32'h1);

    do_reset(1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_pc",    bus.pc_o, 32'(i + 1));
      chk("seq_instr", bus.if_id_instr_o, 32'h100 + 32'(i));
      chk("seq_valid", 32'(bus.if_id_valid_o), 32'h1);
    end
    @(negedge clk);
    chk("pre_stall_pc", bus.pc_o, 32'h5);
    bus.stall_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_pc",    bus.pc_o, 32'h5);
      chk("stall_instr", bus.if_id_instr_o, 32'h104);
      chk("stall_valid", 32'(bus.if_id_valid_o), 32'h1);
    end
    bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h40;
    @(negedge clk);
    chk("br_stall_pc",    bus.pc_o, 32'h40);
    chk("br_stall_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("br_stall_instr", bus.if_id_instr_o, 32'h0);
    clear_inputs();

    bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h80;
    bus.jump_i = 1'b1;         bus.jump_target_i   = 32'h20;
    @(negedge clk);
    chk("br_vs_jmp_pc",    bus.pc_o, 32'h80);
    chk("br_vs_jmp_valid", 32'(bus.if_id_valid_o), 32'h0);
    clear_inputs();
    @(negedge clk);
    chk("after_br_pc",    bus.pc_o, 32'h81);
    chk("after_br_valid", 32'(bus.if_id_valid_o), 32'h1);

    bus.jump_i = 1'b1; bus.jump_target_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("jmp_max_pc", bus.pc_o, 32'hFFFF_FFFF);
    clear_inputs();
    @(negedge clk);
    chk("wrap_pc",    bus.pc_o, 32'h0);
    chk("wrap_pp1",   bus.if_id_pc_plus1_o, 32'h0);
    chk("wrap_valid", 32'(bus.if_id_valid_o), 32'h1);

    mode = 2;
    random_phase(400);

    bus.jump_i = 1'b1; bus.jump_target_i = 32'h10;
    @(negedge clk);
    chk("pre_halt_pc", bus.pc_o, 32'h10);
    clear_inputs();
    bus.halt_i = 1'b1;
    @(negedge clk);
    chk("halt_edge_halted", 32'(bus.halted_o), 32'h1);
    chk("halt_edge_pc",     bus.pc_o, 32'h10);
    bus.halt_i = 1'b0;
    bus.jump_i = 1'b1; bus.jump_target_i = 32'h33;
    repeat (5) begin
      @(negedge clk);
      chk("halt_pc",     bus.pc_o, 32'h10);
      chk("halt_halted", 32'(bus.halted_o), 32'h1);
      chk("halt_valid",  32'(bus.if_id_valid_o), 32'h0);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc",     bus.pc_o, 32'h0);
    chk("async_rst_halted", 32'(bus.halted_o), 32'h0);
    chk("async_rst_valid",  32'(bus.if_id_valid_o), 32'h0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    random_phase(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
